// File: rtl/program_encoder.sv
// Streaming RV32I encoder: packs instruction descriptors into machine words
// and writes them sequentially into instruction memory, expanding LI.
module program_encoder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic              req_funct7_5,
    input  logic [31:0]       req_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic {IDLE, EMIT2} state_t;

    localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_C  = (ADDR_W+1)'(1);

    localparam logic [3:0] K_R      = 4'd0;
    localparam logic [3:0] K_ALUI   = 4'd1;
    localparam logic [3:0] K_LOAD   = 4'd2;
    localparam logic [3:0] K_STORE  = 4'd3;
    localparam logic [3:0] K_BRANCH = 4'd4;
    localparam logic [3:0] K_LUI    = 4'd5;
    localparam logic [3:0] K_AUIPC  = 4'd6;
    localparam logic [3:0] K_JAL    = 4'd7;
    localparam logic [3:0] K_JALR   = 4'd8;
    localparam logic [3:0] K_XORID  = 4'd9;
    localparam logic [3:0] K_LI     = 4'd10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_XORID  = 7'b0001011;

    state_t              state_q, state_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [31:0]         word2_q, word2_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        fit12, fit13, fit21, is_shift;
    logic [19:0] li_hi;
    logic [31:0] enc0, enc1;
    logic        enc_ok, enc_two;
    logic        accept, reject;

    assign imm = req_imm;
    assign rd  = req_rd;
    assign rs1 = req_rs1;
    assign rs2 = req_rs2;
    assign f3  = req_funct3;

    assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);
    assign is_shift = (f3[1:0] == 2'b01);
    // Rounding the upper part lets the ADDI reuse imm[11:0] as its offset.
    assign li_hi = imm[31:12] + {19'd0, imm[11]};

    always_comb begin
        enc0    = '0;
        enc1    = '0;
        enc_ok  = 1'b1;
        enc_two = 1'b0;
        unique case (req_kind)
            K_R:
                enc0 = {1'b0, req_funct7_5, 5'd0, rs2, rs1, f3, rd, OP_R};
            K_ALUI: begin
                if (is_shift) begin
                    enc_ok = ~(|imm[31:5]);
                    enc0 = {1'b0, f3[2] & req_funct7_5, 5'd0, imm[4:0],
                            rs1, f3, rd, OP_ALUI};
                end else begin
                    enc_ok = fit12;
                    enc0 = {imm[11:0], rs1, f3, rd, OP_ALUI};
                end
            end
            K_LOAD: begin
                enc_ok = fit12 && (f3 != 3'b011) && (f3[2:1] != 2'b11);
                enc0 = {imm[11:0], rs1, f3, rd, OP_LOAD};
            end
            K_STORE: begin
                enc_ok = fit12 && (f3 < 3'b011);
                enc0 = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            end
            K_BRANCH: begin
                enc_ok = fit13 && !imm[0] && (f3[2:1] != 2'b01);
                enc0 = {imm[12], imm[10:5], rs2, rs1, f3,
                        imm[4:1], imm[11], OP_BRANCH};
            end
            K_LUI, K_AUIPC: begin
                enc_ok = ~(|imm[11:0]);
                enc0 = {imm[31:12], rd,
                        (req_kind == K_LUI) ? OP_LUI : OP_AUIPC};
            end
            K_JAL: begin
                enc_ok = fit21 && !imm[0];
                enc0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            K_JALR: begin
                enc_ok = fit12;
                enc0 = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            end
            K_XORID: begin
                enc_ok = fit12;
                enc0 = {imm[11:0], rs1, 3'b100, rd, OP_XORID};
            end
            K_LI: begin
                if (fit12) begin
                    enc0 = {imm[11:0], 5'd0, 3'b000, rd, OP_ALUI};
                end else begin
                    enc_two = 1'b1;
                    enc0 = {li_hi, rd, OP_LUI};
                    enc1 = {imm[11:0], rd, 3'b000, rd, OP_ALUI};
                end
            end
            default:
                enc_ok = 1'b0;
        endcase
    end

    assign accept = req_valid && req_ready;
    assign reject = !enc_ok || (enc_two && (count_q == LAST_C));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept && !reject && enc_two) state_d = EMIT2;
                EMIT2:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE) && !full_q && !clr;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        word2_d   = word2_q;
        count_d   = count_q;
        err_d     = err_q;
        if (clr) begin
            wr_addr_d = '0;
            count_d   = '0;
            err_d     = 1'b0;
        end else if (state_q == EMIT2) begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q[ADDR_W-1:0];
            wr_data_d = word2_q;
            count_d   = count_q + ONE_C;
        end else if (accept) begin
            if (reject) begin
                err_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = count_q[ADDR_W-1:0];
                wr_data_d = enc0;
                word2_d   = enc1;
                count_d   = count_q + ONE_C;
            end
        end
        full_d = (count_d == FULL_C);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            word2_q   <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            word2_q   <= word2_d;
            count_q   <= count_d;
            full_q    <= full_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign count   = count_q;
    assign full    = full_q;
    assign err     = err_q;

endmodule

// File: tb/tb_program_encoder.sv
// Bench for program_encoder: directed scenarios plus randomized descriptors
// checked against an arithmetic encoding model; small DEPTH exercises full.
module tb_program_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clr = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_kind = '0;
    logic [4:0]    req_rd = '0;
    logic [4:0]    req_rs1 = '0;
    logic [4:0]    req_rs2 = '0;
    logic [2:0]    req_funct3 = '0;
    logic          req_funct7_5 = 1'b0;
    logic [31:0]   req_imm = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    int checks = 0;
    int errors = 0;
    int m_count = 0;
    bit m_err = 0;

    program_encoder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_funct3(req_funct3),
        .req_funct7_5(req_funct7_5), .req_imm(req_imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void model(
        input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [2:0] f3, input logic f75,
        input logic [31:0] imm, output bit ok, output int n,
        output logic [31:0] w0, output logic [31:0] w1);
        int si;
        bit fit12;
        logic [31:0] d, s1, s2, f, i12, hi, lo;
        si = $signed(imm);
        fit12 = (si >= -2048) && (si < 2048);
        d = 32'(rd) << 7;
        s1 = 32'(rs1) << 15;
        s2 = 32'(rs2) << 20;
        f = 32'(f3) << 12;
        i12 = (imm & 32'hFFF) << 20;
        ok = 1; n = 1; w0 = 0; w1 = 0;
        case (k)
            0: w0 = 32'h33 | d | f | s1 | s2 | (32'(f75) << 30);
            1: begin
                if (f3 == 1 || f3 == 5) begin
                    ok = (imm < 32);
                    w0 = 32'h13 | d | f | s1 | ((imm & 31) << 20)
                       | ((f3 == 5) ? (32'(f75) << 30) : 32'd0);
                end else begin
                    ok = fit12;
                    w0 = 32'h13 | d | f | s1 | i12;
                end
            end
            2: begin
                ok = fit12 && !(f3 inside {3'd3, 3'd6, 3'd7});
                w0 = 32'h03 | d | f | s1 | i12;
            end
            3: begin
                ok = fit12 && (f3 < 3);
                w0 = 32'h23 | ((imm & 31) << 7) | f | s1 | s2
                   | (((imm >> 5) & 127) << 25);
            end
            4: begin
                ok = (si >= -4096) && (si < 4096) && (imm % 2 == 0)
                   && (f3 != 2) && (f3 != 3);
                w0 = 32'h63 | (((imm >> 11) & 1) << 7)
                   | (((imm >> 1) & 15) << 8) | f | s1 | s2
                   | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
            end
            5, 6: begin
                ok = ((imm & 32'hFFF) == 0);
                w0 = ((k == 5) ? 32'h37 : 32'h17) | d | (imm & 32'hFFFFF000);
            end
            7: begin
                ok = (si >= -1048576) && (si < 1048576) && (imm % 2 == 0);
                w0 = 32'h6F | d | (imm & 32'hFF000)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 1) & 1023) << 21)
                   | (((imm >> 20) & 1) << 31);
            end
            8: begin
                ok = fit12;
                w0 = 32'h67 | d | s1 | i12;
            end
            9: begin
                ok = fit12;
                w0 = 32'h0B | d | (32'd4 << 12) | s1 | i12;
            end
            10: begin
                if (fit12) begin
                    w0 = 32'h13 | d | i12;
                end else begin
                    hi = (imm + 32'h800) & 32'hFFFFF000;
                    lo = imm - hi;
                    n = 2;
                    w0 = 32'h37 | d | hi;
                    w1 = 32'h13 | d | (32'(rd) << 15) | ((lo & 32'hFFF) << 20);
                end
            end
            default: ok = 0;
        endcase
    endfunction

    task automatic drive(
        input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [2:0] f3, input logic f75,
        input logic [31:0] imm, output logic rdy);
        @(negedge clk);
        req_kind = k; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_funct3 = f3; req_funct7_5 = f75; req_imm = imm;
        req_valid = 1'b1;
        #1 rdy = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        m_count = 0;
        m_err = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_wr: got en=%b addr=%0d data=%h want 0/0/0",
                     wr_en, wr_addr, wr_data);
        end
        checks++;
        if (count !== '0 || full !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got count=%0d full=%b err=%b want 0/0/0",
                     count, full, err);
        end
        @(negedge clk);
        reset = 1'b1;
        m_count = 0;
        m_err = 0;
    endtask

    task automatic test_basic();
        logic rdy;
        drive(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, rdy);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd0 || wr_data !== 32'h002081B3) begin
            errors++;
            $display("FAIL add: got en=%b addr=%0d data=%h want 1/0/002081b3",
                     wr_en, wr_addr, wr_data);
        end
        drive(4'd9, 5'd4, 5'd4, 5'd0, 3'd0, 1'b0, 32'h68, rdy);
        checks++;
        if (wr_addr !== 2'd1 || wr_data !== 32'h0682420B || count !== 3'd2) begin
            errors++;
            $display("FAIL xorid: got addr=%0d data=%h count=%0d want 1/0682420b/2",
                     wr_addr, wr_data, count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width: got wr_en=%b want 0", wr_en);
        end
        m_count = 2;
    endtask

    task automatic test_branch();
        logic rdy;
        drive(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFF8, rdy);
        checks++;
        if (wr_en !== 1'b1 || wr_data !== 32'hFE208CE3 || wr_addr !== 2'd2) begin
            errors++;
            $display("FAIL branch: got en=%b addr=%0d data=%h want 1/2/fe208ce3",
                     wr_en, wr_addr, wr_data);
        end
        m_count = 3;
    endtask

    task automatic test_li();
        logic rdy;
        do_clr();
        drive(4'd10, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF, rdy);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd0 || wr_data !== 32'h123462B7) begin
            errors++;
            $display("FAIL li_hi: got en=%b addr=%0d data=%h want 1/0/123462b7",
                     wr_en, wr_addr, wr_data);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL li_ready: got req_ready=%b want 0", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd1 || wr_data !== 32'hFFF28293) begin
            errors++;
            $display("FAIL li_lo: got en=%b addr=%0d data=%h want 1/1/fff28293",
                     wr_en, wr_addr, wr_data);
        end
        drive(4'd10, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF, rdy);
        checks++;
        if (wr_addr !== 2'd2 || wr_data !== 32'hFFF00293 || count !== 3'd3) begin
            errors++;
            $display("FAIL li_small: got addr=%0d data=%h count=%0d want 2/fff00293/3",
                     wr_addr, wr_data, count);
        end
    endtask

    task automatic test_errors();
        logic rdy;
        do_clr();
        drive(4'd1, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd2048, rdy);
        checks++;
        if (wr_en !== 1'b0 || err !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL addi_range: got en=%b err=%b count=%0d want 0/1/0",
                     wr_en, err, count);
        end
        drive(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3, rdy);
        checks++;
        if (wr_en !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL branch_odd: got en=%b err=%b want 0/1", wr_en, err);
        end
        do_clr();
        checks++;
        if (err !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL clr: got err=%b count=%0d want 0/0", err, count);
        end
    endtask

    task automatic test_full();
        logic rdy;
        do_clr();
        repeat (3) drive(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, rdy);
        drive(4'd10, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, rdy);
        checks++;
        if (wr_en !== 1'b0 || err !== 1'b1 || count !== 3'd3
            || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL li_last_slot: got en=%b err=%b count=%0d rdy=%b want 0/1/3/1",
                     wr_en, err, count, req_ready);
        end
        drive(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, rdy);
        checks++;
        if (wr_addr !== 2'd3 || count !== 3'd4 || full !== 1'b1
            || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill: got addr=%0d count=%0d full=%b rdy=%b want 3/4/1/0",
                     wr_addr, count, full, req_ready);
        end
        drive(4'd15, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, rdy);
        checks++;
        if (rdy !== 1'b0 || wr_en !== 1'b0 || count !== 3'd4 || err !== 1'b1) begin
            errors++;
            $display("FAIL full_ignore: got rdy=%b en=%b count=%0d err=%b want 0/0/4/1",
                     rdy, wr_en, count, err);
        end
    endtask

    task automatic test_reset_emit2();
        logic rdy;
        do_clr();
        drive(4'd10, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF, rdy);
        reset = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got en=%b count=%0d want 0/0", wr_en, count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL no_second_word: got wr_en=%b want 0", wr_en);
        end
        @(negedge clk);
        reset = 1'b1;
        m_count = 0;
        m_err = 0;
        drive(4'd0, 5'd7, 5'd6, 5'd5, 3'd0, 1'b1, 32'd0, rdy);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd0 || wr_data !== 32'h405303B3) begin
            errors++;
            $display("FAIL post_reset: got en=%b addr=%0d data=%h want 1/0/405303b3",
                     wr_en, wr_addr, wr_data);
        end
        m_count = 1;
    endtask

    task automatic test_random();
        logic rdy;
        logic [3:0] k;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic f75;
        logic [31:0] imm, w0, w1;
        bit ok;
        int n;
        for (int i = 0; i < 400; i++) begin
            if (m_count == DEPTH) begin
                checks++;
                if (req_ready !== 1'b0 || full !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_full: got rdy=%b full=%b want 0/1",
                             req_ready, full);
                end
                do_clr();
                continue;
            end
            k = 4'($urandom_range(0, 12));
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            f3 = 3'($urandom); f75 = 1'($urandom);
            case ($urandom_range(0, 3))
                0: imm = $urandom_range(0, 40);
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm = $urandom;
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            model(k, rd, rs1, rs2, f3, f75, imm, ok, n, w0, w1);
            drive(k, rd, rs1, rs2, f3, f75, imm, rdy);
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL rnd_ready: got %b want 1", rdy);
            end
            if (!ok || (n == 2 && m_count == DEPTH - 1)) begin
                m_err = 1;
                checks++;
                if (wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_reject: kind=%0d imm=%h got wr_en=%b want 0",
                             k, imm, wr_en);
                end
            end else begin
                checks++;
                if (wr_en !== 1'b1 || wr_addr !== AW'(m_count) || wr_data !== w0) begin
                    errors++;
                    $display("FAIL rnd_word: kind=%0d imm=%h got en=%b addr=%0d data=%h want 1/%0d/%h",
                             k, imm, wr_en, wr_addr, wr_data, m_count, w0);
                end
                m_count++;
                if (n == 2) begin
                    checks++;
                    if (req_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_emit2_ready: got %b want 0", req_ready);
                    end
                    @(posedge clk);
                    #1;
                    checks++;
                    if (wr_en !== 1'b1 || wr_addr !== AW'(m_count) || wr_data !== w1) begin
                        errors++;
                        $display("FAIL rnd_word2: imm=%h got en=%b addr=%0d data=%h want 1/%0d/%h",
                                 imm, wr_en, wr_addr, wr_data, m_count, w1);
                    end
                    m_count++;
                end
            end
            checks++;
            if (count !== (AW+1)'(m_count) || err !== m_err
                || full !== (m_count == DEPTH)) begin
                errors++;
                $display("FAIL rnd_state: got count=%0d err=%b full=%b want %0d/%b/%b",
                         count, err, full, m_count, m_err, m_count == DEPTH);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_li();
        test_errors();
        test_full();
        test_reset_emit2();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
